// File: rtl/seg_scan_decoder.sv
// Receive side of the 8-digit multiplexed 7-segment scan bus: samples seg_d/seg_com,
// filters each digit dwell for stability, decodes back to BCD and reassembles frames.
module seg_scan_decoder #(
  parameter int STABLE_CNT = 4,
  parameter int TO_W       = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_d,
  input  logic [7:0]  seg_com,
  output logic [31:0] bcd8d,
  output logic [7:0]  dots,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        com_err,
  output logic        stale
);

  localparam logic [3:0]      CNT_MAX = 4'(STABLE_CNT);
  localparam logic [3:0]      CNT_HIT = 4'(STABLE_CNT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = '1;

  logic [7:0]      s_d, s_com, p_d, p_com;
  logic [3:0]      cnt;
  logic [31:0]     shadow;
  logic [7:0]      shadow_dot;
  logic [7:0]      mask;
  logic            err_acc;
  logic [TO_W-1:0] to_cnt;

  logic       com_zero, com_onehot, same, latch, commit, to_hit, dec_err;
  logic [2:0] idx;
  logic [3:0] dec_val;

  always_comb begin
    com_zero   = (s_com == 8'h00);
    com_onehot = !com_zero && ((s_com & (s_com - 8'd1)) == 8'h00);
    same       = ({s_d, s_com} == {p_d, p_com});
    latch      = com_onehot && same && (cnt == CNT_HIT);
    commit     = (mask == 8'hFF);
    // saturation takes effect on the edge where the counter reaches all-ones
    to_hit     = !commit && (to_cnt == TO_MAX - 1'b1);
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (s_com[i]) idx = 3'(i);
    end
    dec_err = 1'b0;
    unique case (s_d[6:0])
      7'h3f:   dec_val = 4'd0;
      7'h06:   dec_val = 4'd1;
      7'h5b:   dec_val = 4'd2;
      7'h4f:   dec_val = 4'd3;
      7'h66:   dec_val = 4'd4;
      7'h6d:   dec_val = 4'd5;
      7'h7d:   dec_val = 4'd6;
      7'h27:   dec_val = 4'd7;
      7'h7f:   dec_val = 4'd8;
      7'h6f:   dec_val = 4'd9;
      7'h00:   dec_val = 4'hF;
      default: begin
        dec_val = 4'hE;
        dec_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_d         <= '0;
      s_com       <= '0;
      p_d         <= '0;
      p_com       <= '0;
      cnt         <= '0;
      shadow      <= '0;
      shadow_dot  <= '0;
      mask        <= '0;
      err_acc     <= 1'b0;
      to_cnt      <= '0;
      bcd8d       <= '0;
      dots        <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      com_err     <= 1'b0;
      stale       <= 1'b0;
    end else begin
      s_d   <= seg_d;
      s_com <= seg_com;
      p_d   <= s_d;
      p_com <= s_com;

      if (!com_onehot || !same) cnt <= '0;
      else if (cnt < CNT_MAX)   cnt <= cnt + 4'd1;

      com_err <= !com_zero && !com_onehot;

      if (latch) begin
        shadow[{idx, 2'b00} +: 4] <= dec_val;
        shadow_dot[idx]           <= s_d[7];
      end

      // a latch coinciding with commit/timeout seeds the next frame
      if (commit || to_hit) begin
        mask    <= latch ? s_com : 8'h00;
        err_acc <= latch && dec_err;
      end else if (latch) begin
        mask    <= mask | s_com;
        err_acc <= err_acc | dec_err;
      end

      frame_valid <= commit;
      if (commit) begin
        bcd8d     <= shadow;
        dots      <= shadow_dot;
        frame_err <= err_acc;
        to_cnt    <= '0;
        stale     <= 1'b0;
      end else begin
        if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
        if (to_hit)           stale  <= 1'b1;
      end
    end
  end

endmodule
